// File: rtl/vga_pixel_pipeline_if.sv
// rtl/vga_pixel_pipeline_if.sv - pixel stream from the VGA timing generator
// Purpose: carries the per-pixel x/y/active/sync stream into the pixel pipeline.
// Signals:
//   active_in      visible-area flag
//   screen_end_in  one-cycle end-of-frame pulse
//   hsync_in       horizontal sync, low during the pulse
//   vsync_in       vertical sync, low during the pulse
//   x_in[9:0]      pixel x, 0 outside the visible width
//   y_in[8:0]      pixel y, 0 outside the visible height
// Modports: master = timing generator (drives), slave = pixel pipeline (receives).
interface vga_pixel_pipeline_if;
  logic       active_in;
  logic       screen_end_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] x_in;
  logic [8:0] y_in;

  modport master (
    output active_in, screen_end_in, hsync_in, vsync_in, x_in, y_in
  );

  modport slave (
    input  active_in, screen_end_in, hsync_in, vsync_in, x_in, y_in
  );
endinterface

// File: rtl/vga_pixel_pipeline.sv
// rtl/vga_pixel_pipeline.sv - framebuffer addressing, palette lookup and cursor overlay
// Purpose: turns the timing generator's pixel stream into blanked 12-bit RGB with
// syncs delayed by PIPE = RAM_LATENCY+3 cycles so they line up with the colour.
// Ports:
//   clk25, reset                 pixel clock, asynchronous active-high reset
//   vid (slave)                  x/y/active/sync/screen_end stream
//   fb_addr[18:0] / fb_data[7:0] framebuffer read address / palette index
//   cursor_x_in/_y_in/_en_in     requested cursor, taken at screen_end only
//   pal_we/pal_waddr/pal_wdata   palette write port
//   rgb_out, hsync_out, vsync_out pipelined pixel output
//   frame_count[15:0]            completed-frame counter
module vga_pixel_pipeline #(
  parameter int          WIDTH        = 640,
  parameter int          HEIGHT       = 480,
  parameter int          RAM_LATENCY  = 1,
  parameter int          CURSOR_SIZE  = 8,
  parameter logic [11:0] CURSOR_COLOR = 12'hFFF
) (
  input  logic                 clk25,
  input  logic                 reset,
  vga_pixel_pipeline_if.slave  vid,
  output logic [18:0]          fb_addr,
  input  logic [7:0]           fb_data,
  input  logic [9:0]           cursor_x_in,
  input  logic [8:0]           cursor_y_in,
  input  logic                 cursor_en_in,
  input  logic                 pal_we,
  input  logic [7:0]           pal_waddr,
  input  logic [11:0]          pal_wdata,
  output logic [11:0]          rgb_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic [15:0]          frame_count
);

  localparam int PIPE = RAM_LATENCY + 3;

  logic [11:0]     r_palette [256];
  logic [11:0]     r_pal_color;
  logic [9:0]      r_cur_x;
  logic [8:0]      r_cur_y;
  logic            r_cur_en;
  logic [18:0]     r_fb_addr;
  logic [11:0]     r_rgb;
  logic [15:0]     r_frame_count;
  // Syncs need the full PIPE stages; active/hit are consumed one stage earlier
  // by the registered colour mux, so their lines stop at PIPE-1.
  logic [PIPE-1:0] r_hs_dl;
  logic [PIPE-1:0] r_vs_dl;
  logic [PIPE-2:0] r_act_dl;
  logic [PIPE-2:0] r_hit_dl;

  logic [10:0]     w_x;
  logic [10:0]     w_y;
  logic [10:0]     w_cx;
  logic [10:0]     w_cy;
  logic [10:0]     w_cx_end;
  logic [10:0]     w_cy_end;
  logic            w_hit;
  logic [18:0]     w_addr;

  // 11-bit compare space: a cursor near the right/bottom edge clips instead of
  // wrapping its far edge back around to column/row 0.
  assign w_x      = {1'b0, vid.x_in};
  assign w_y      = {2'b0, vid.y_in};
  assign w_cx     = {1'b0, r_cur_x};
  assign w_cy     = {2'b0, r_cur_y};
  assign w_cx_end = w_cx + 11'(CURSOR_SIZE);
  assign w_cy_end = w_cy + 11'(CURSOR_SIZE);
  assign w_hit    = r_cur_en
                    && (w_x >= w_cx) && (w_x < w_cx_end)
                    && (w_y >= w_cy) && (w_y < w_cy_end)
                    && (w_x < 11'(WIDTH)) && (w_y < 11'(HEIGHT));

  // Full 19-bit product: the last visible pixel lands at 307199.
  assign w_addr = 19'(vid.y_in) * 19'(WIDTH) + 19'(vid.x_in);

  // Palette: not reset; read-before-write gives the old value on a collision.
  always_ff @(posedge clk25) begin
    if (pal_we) begin
      r_palette[pal_waddr] <= pal_wdata;
    end
    r_pal_color <= r_palette[fb_data];
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_fb_addr     <= '0;
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_cur_en      <= 1'b0;
      r_frame_count <= '0;
      r_hs_dl       <= '1;
      r_vs_dl       <= '1;
      r_act_dl      <= '0;
      r_hit_dl      <= '0;
      r_rgb         <= '0;
    end else begin
      r_fb_addr <= vid.active_in ? w_addr : 19'd0;

      // Shadow cursor only moves at frame end; pixels already in flight keep
      // the hit they were evaluated with.
      if (vid.screen_end_in) begin
        r_cur_x       <= cursor_x_in;
        r_cur_y       <= cursor_y_in;
        r_cur_en      <= cursor_en_in;
        r_frame_count <= r_frame_count + 16'd1;
      end

      r_hs_dl  <= {r_hs_dl[PIPE-2:0], vid.hsync_in};
      r_vs_dl  <= {r_vs_dl[PIPE-2:0], vid.vsync_in};
      r_act_dl <= {r_act_dl[PIPE-3:0], vid.active_in};
      r_hit_dl <= {r_hit_dl[PIPE-3:0], w_hit};

      if (!r_act_dl[PIPE-2]) begin
        r_rgb <= 12'h000;
      end else if (r_hit_dl[PIPE-2]) begin
        r_rgb <= CURSOR_COLOR;
      end else begin
        r_rgb <= r_pal_color;
      end
    end
  end

  assign fb_addr     = r_fb_addr;
  assign rgb_out     = r_rgb;
  assign hsync_out   = r_hs_dl[PIPE-1];
  assign vsync_out   = r_vs_dl[PIPE-1];
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// tb/tb_vga_pixel_pipeline.sv - scoreboard bench for vga_pixel_pipeline at RAM_LATENCY 1..3
module tb_vga_pixel_pipeline;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  logic        reset;
  vga_pixel_pipeline_if vif();
  logic [9:0]  cursor_x_in;
  logic [8:0]  cursor_y_in;
  logic        cursor_en_in;
  logic        pal_we;
  logic [7:0]  pal_waddr;
  logic [11:0] pal_wdata;

  logic [18:0] fb_addr     [NDUT];
  logic [7:0]  fb_data     [NDUT];
  logic [11:0] rgb_out     [NDUT];
  logic        hsync_out   [NDUT];
  logic        vsync_out   [NDUT];
  logic [15:0] frame_count [NDUT];

  bit fb_const;

  function automatic logic [7:0] fbv(logic [18:0] a);
    return fb_const ? 8'h05 : (a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]});
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int RL = g + 1;
    logic [7:0] r_dl [RL];

    always @(posedge clk25) begin
      r_dl[0] <= fbv(fb_addr[g]);
      for (int k = 1; k < RL; k++) r_dl[k] <= r_dl[k-1];
    end
    assign fb_data[g] = r_dl[RL-1];

    vga_pixel_pipeline #(.RAM_LATENCY(RL)) u_dut (
      .clk25        (clk25),
      .reset        (reset),
      .vid          (vif.slave),
      .fb_addr      (fb_addr[g]),
      .fb_data      (fb_data[g]),
      .cursor_x_in  (cursor_x_in),
      .cursor_y_in  (cursor_y_in),
      .cursor_en_in (cursor_en_in),
      .pal_we       (pal_we),
      .pal_waddr    (pal_waddr),
      .pal_wdata    (pal_wdata),
      .rgb_out      (rgb_out[g]),
      .hsync_out    (hsync_out[g]),
      .vsync_out    (vsync_out[g]),
      .frame_count  (frame_count[g])
    );
  end

  int total = 0;
  int bad   = 0;

  exp_t        q_pix  [NDUT][$];
  logic [18:0] q_addr [NDUT][$];
  logic [11:0] pal_m  [256];
  logic [9:0]  sh_x;
  logic [8:0]  sh_y;
  bit          sh_en;
  logic [15:0] fc_m;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic init_model();
    exp_t e;
    e.rgb = 12'h000;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      q_pix[g].delete();
      q_addr[g].delete();
      // PIPE-1 flush entries: blank with syncs high until fresh input emerges
      for (int k = 0; k < g + 3; k++) q_pix[g].push_back(e);
    end
    sh_en = 1'b0;
    sh_x  = '0;
    sh_y  = '0;
    fc_m  = '0;
  endtask

  task automatic step(bit act, bit se, bit hs, bit vs, int x, int y);
    int   addr;
    bit   hit;
    exp_t e;
    vif.active_in     = act;
    vif.screen_end_in = se;
    vif.hsync_in      = hs;
    vif.vsync_in      = vs;
    vif.x_in          = act ? 10'(x) : 10'd0;
    vif.y_in          = act ? 9'(y) : 9'd0;
    addr  = act ? (y * 640 + x) : 0;
    hit   = sh_en && (x >= int'(sh_x)) && (x < int'(sh_x) + 8)
                  && (y >= int'(sh_y)) && (y < int'(sh_y) + 8);
    e.rgb = !act ? 12'h000 : (hit ? 12'hFFF : pal_m[fbv(19'(addr))]);
    e.hs  = hs;
    e.vs  = vs;
    for (int g = 0; g < NDUT; g++) begin
      q_pix[g].push_back(e);
      q_addr[g].push_back(19'(addr));
    end
    if (se) begin
      sh_x  = cursor_x_in;
      sh_y  = cursor_y_in;
      sh_en = cursor_en_in;
      fc_m  = fc_m + 16'd1;
    end
    if (pal_we) pal_m[pal_waddr] = pal_wdata;
    @(posedge clk25);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      logic [18:0] a;
      e = q_pix[g].pop_front();
      a = q_addr[g].pop_front();
      check($sformatf("rgb_rl%0d", g + 1),   32'(rgb_out[g]),     32'(e.rgb));
      check($sformatf("hsync_rl%0d", g + 1), 32'(hsync_out[g]),   32'(e.hs));
      check($sformatf("vsync_rl%0d", g + 1), 32'(vsync_out[g]),   32'(e.vs));
      check($sformatf("fbaddr_rl%0d", g + 1), 32'(fb_addr[g]),    32'(a));
      check($sformatf("fcount_rl%0d", g + 1), 32'(frame_count[g]), 32'(fc_m));
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 1, 1, 0, 0);
  endtask

  task automatic pal_write(logic [7:0] a, logic [11:0] d);
    pal_we    = 1'b1;
    pal_waddr = a;
    pal_wdata = d;
    step(0, 0, 1, 1, 0, 0);
    pal_we    = 1'b0;
  endtask

  task automatic line(int y);
    for (int x = 0; x < 8; x++)     step(1, 0, 1, 1, x, y);
    for (int x = 628; x < 640; x++) step(1, 0, 1, 1, x, y);
    repeat (2) step(0, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 1, 1, 0, 0);
  endtask

  // Compressed frame: edge columns of a handful of lines, then vertical blanking.
  // When upd is set the cursor request changes mid-frame, after line 98.
  task automatic frame(bit upd, logic [9:0] cx, logic [8:0] cy, bit cen);
    line(0);
    line(1);
    for (int y = 98; y < 110; y++) begin
      line(y);
      if (upd && y == 98) begin
        cursor_x_in  = cx;
        cursor_y_in  = cy;
        cursor_en_in = cen;
      end
    end
    for (int y = 476; y < 480; y++) line(y);
    repeat (2) step(0, 0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    repeat (4) step(0, 0, 1, 1, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("rst_rgb_rl%0d", g + 1),   32'(rgb_out[g]),     32'h0);
      check($sformatf("rst_hsync_rl%0d", g + 1), 32'(hsync_out[g]),   32'h1);
      check($sformatf("rst_vsync_rl%0d", g + 1), 32'(vsync_out[g]),   32'h1);
      check($sformatf("rst_fcount_rl%0d", g + 1), 32'(frame_count[g]), 32'h0);
      check($sformatf("rst_fbaddr_rl%0d", g + 1), 32'(fb_addr[g]),    32'h0);
    end
    repeat (3) @(posedge clk25);
    #1;
    reset = 1'b0;
    init_model();
  endtask

  initial begin
    reset             = 1'b0;
    vif.active_in     = 1'b0;
    vif.screen_end_in = 1'b0;
    vif.hsync_in      = 1'b1;
    vif.vsync_in      = 1'b1;
    vif.x_in          = '0;
    vif.y_in          = '0;
    cursor_x_in       = '0;
    cursor_y_in       = '0;
    cursor_en_in      = 1'b0;
    pal_we            = 1'b0;
    pal_waddr         = '0;
    pal_wdata         = '0;
    fb_const          = 1'b0;
    #5;
    do_reset();

    for (int i = 0; i < 256; i++) pal_write(8'(i), 12'($urandom));

    // Constant framebuffer index 0x05 -> every visible pixel is 12'hA5C
    fb_const = 1'b1;
    pal_write(8'h05, 12'hA5C);
    idle(8);
    frame(0, '0, '0, 0);
    idle(8);
    fb_const = 1'b0;
    idle(8);

    // Cursor at the right edge: requested mid-frame, drawn only next frame
    frame(1, 10'd636, 9'd100, 1);
    frame(0, '0, '0, 0);
    // Cursor at the bottom-right corner clips without wrapping to row/column 0
    frame(1, 10'd636, 9'd476, 1);
    frame(0, '0, '0, 0);
    // Corner whose far edge would wrap in narrow arithmetic
    frame(1, 10'd1020, 9'd508, 1);
    frame(0, '0, '0, 0);

    // Reset mid-line, then a fresh frame
    for (int x = 0; x < 5; x++) step(1, 0, 1, 1, x, 200);
    do_reset();
    frame(0, '0, '0, 0);

    // Frame counter wrap: 65536 end-of-frame pulses from reset
    do_reset();
    repeat (65536) step(0, 1, 1, 1, 0, 0);
    for (int g = 0; g < NDUT; g++)
      check($sformatf("fc_wrap_rl%0d", g + 1), 32'(frame_count[g]), 32'h0);
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipeline.md
# vga_pixel_pipeline

Pixel-side stage directly downstream of the VGA timing generator. It converts the generator's x/y/active/sync stream into framebuffer read addresses, looks the returned 8-bit palette index up in a 256-entry 12-bit colour palette, and overlays a frame-synchronous square cursor. It emits blanked 12-bit RGB with hSync/vSync delayed to match the pixel latency exactly.

## Interface
- WIDTH, 640, visible pixels per line; also the address stride
- HEIGHT, 480, visible lines per frame
- RAM_LATENCY, 1, framebuffer read latency in cycles (legal range 1..3)
- CURSOR_SIZE, 8, cursor edge length in pixels
- CURSOR_COLOR, 12'hFFF, RGB drawn inside the cursor

Ports:
- clk25  in  1  25 MHz pixel clock
- reset  in  1  reset, asynchronous, active-high
- active_in  in  1  visible-area flag from the timing generator
- screen_end_in  in  1  one-cycle end-of-frame pulse
- hsync_in  in  1  horizontal sync (low during the sync pulse)
- vsync_in  in  1  vertical sync (low during the sync pulse)
- x_in  in  10  pixel x; 0 when outside the visible width
- y_in  in  9  pixel y; 0 when outside the visible height
- fb_addr  out  19  framebuffer read address
- fb_data  in  8  palette index, valid RAM_LATENCY cycles after fb_addr
- cursor_x_in, cursor_y_in  in  10/9  requested cursor top-left corner
- cursor_en_in  in  1  requested cursor enable
- pal_we  in  1  palette write strobe
- pal_waddr  in  8  palette write index
- pal_wdata  in  12  palette write data {R[3:0],G[3:0],B[3:0]}
- rgb_out  out  12  output colour
- hsync_out, vsync_out  out  1  delayed syncs
- frame_count  out  16  completed-frame counter

## Operation
- Stage A (registered) samples the inputs at cycle T.
  - fb_addr = y_in*WIDTH + x_in when active_in is high, else 0.
  - The product is computed at 19 bits and must not truncate for 639 + 479*640 = 307199.
- Stage B: fb_data arrives at T+1+RAM_LATENCY.
- Stage C (registered): pal_color = palette[fb_data].
- Stage D (registered): rgb_out is chosen in this priority order:
  - 0 when the delayed active flag is low;
  - else CURSOR_COLOR when the delayed cursor hit is set;
  - else pal_color.
- Cursor hit is evaluated in stage A on the shadow registers.
  - Condition: shadow_en, cx ≤ x < cx+CURSOR_SIZE, and cy ≤ y < cy+CURSOR_SIZE.
  - The sums use 11 bits, so a cursor at the right or bottom edge clips and never wraps to x or y = 0.
  - The hit flag is delayed to stage D.
- Shadow cursor registers load cursor_x_in/cursor_y_in/cursor_en_in only on cycles where screen_end_in = 1. Changes mid-frame never tear.
- Palette writes:
  - Synchronous, on clk25 when pal_we = 1.
  - If a read and a write hit the same address in the same cycle, the read returns the old value.
  - Palette contents are not reset.
- frame_count increments on every screen_end_in cycle and wraps from 16'hFFFF to 0.
- hsync_in, vsync_in and active_in travel through a shift register of depth PIPE = RAM_LATENCY+3, so they stay aligned with rgb_out.

## Timing
- Latency from inputs at cycle T to rgb_out, hsync_out and vsync_out: T+PIPE (4 cycles at default).
- fb_addr is valid at T+1.
- Throughput is one pixel per clk25 cycle, with no stalls and no back-pressure.
- Reset (any time, including mid-frame), all asynchronous:
  - rgb_out = 0, fb_addr = 0, hsync_out = 1, vsync_out = 1, frame_count = 0;
  - shadow cursor = 0 and disabled; all delay-line stages cleared to active = 0, syncs = 1.
- First release behaviour: after reset deasserts, outputs stay blanked with syncs high until PIPE cycles of fresh input have flushed through.
- screen_end_in together with a cursor change in the same cycle: the new value is captured, and the old value still applies to the pixels already in flight.

## Test plan
- Palette: write palette[0x05] = 12'hA5C and fill the framebuffer model with 0x05, then run one frame → every active pixel is 12'hA5C, and rgb_out = 0 in all blanking cycles.
- Alignment: at x = 0, y = 0, the first rgb_out and the hsync_in falling edge both appear exactly PIPE cycles later. Repeat with RAM_LATENCY = 1, 2 and 3.
- Addressing: x = 639, y = 479 → fb_addr = 307199 one cycle later. Any inactive cycle → fb_addr = 0.
- Cursor: request cursor at (636, 100) with enable, mid-frame.
  - Nothing drawn in the current frame.
  - Next frame: x 636..639, y 100..107 equal 12'hFFF, and x 0..3 on those lines keep the palette colour (no wrap).
- Frame counter: preload via 65536 screen_end_in pulses → frame_count wraps to 0.
- Reset: assert reset mid-line for 3 cycles → outputs immediately blank, syncs go to 1 and frame_count goes to 0. Correct pixels resume PIPE cycles after fresh input.
